// File: rtl/mem_ctrl_pkg.sv
// Shared FSM state type and sizing helpers for the main-memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Address width for the default geometry (TAG_BITS + INDEX_BITS).
    localparam int ADDR_BITS = 24 + 7;

    function automatic int addr_width(input int tag_bits, input int index_bits);
        return tag_bits + index_bits;
    endfunction

    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// One-hot grant over the port request vector. Fixed priority by default;
// round-robin with a rotating start pointer when MEM_RR_ARB_EN is defined.
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
`ifdef MEM_RR_ARB_EN
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         advance_i,
`endif
    input  logic [NUM_PORTS-1:0]         req_i,
    output logic [NUM_PORTS-1:0]         grant_o,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx_o
);

    localparam int GW = $clog2(NUM_PORTS);

    logic [GW-1:0] start;

`ifdef MEM_RR_ARB_EN
    // ptr_q is the first port searched: the one after the last grant.
    logic [GW-1:0] ptr_q;
    logic [GW-1:0] ptr_d;

    assign ptr_d = (grant_idx_o == GW'(NUM_PORTS - 1)) ? '0 : grant_idx_o + 1'b1;
    assign start = ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start = '0;
`endif

    always_comb begin
        int  j;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        j           = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(start) + i;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (!found && req_i[GW'(j)]) begin
                found              = 1'b1;
                grant_o[GW'(j)]    = 1'b1;
                grant_idx_o        = GW'(j);
            end
        end
    end

endmodule

// File: rtl/main_memory_ctrl.sv
// Multi-port main-memory controller: arbitrated block access with a fixed
// BUSY latency and out-of-range rejection. MEM_RR_ARB_EN selects round-robin.
module main_memory_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 24,
    parameter int BLOCK_SIZE = 512,
    parameter int NO_OF_SETS = 1950,
    parameter int LATENCY    = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_PORTS-1:0]            mem_rd,
    input  logic [NUM_PORTS-1:0]            mem_wr,
    input  logic [NUM_PORTS*INDEX_BITS-1:0] index_in,
    input  logic [NUM_PORTS*TAG_BITS-1:0]   tag_in,
    input  logic [NUM_PORTS*BLOCK_SIZE-1:0] wdata_in,
    output logic [BLOCK_SIZE-1:0]           rdata_out,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [NUM_PORTS-1:0]            done,
    output logic [NUM_PORTS-1:0]            invalid_addr,
    output logic                            busy
);

    localparam int AW = addr_width(TAG_BITS, INDEX_BITS);
    localparam int CW = cnt_width(LATENCY);
    localparam int MW = (NO_OF_SETS > 1) ? $clog2(NO_OF_SETS) : 1;
    localparam int GW = $clog2(NUM_PORTS);
    localparam logic [AW:0] SETS = (AW + 1)'(NO_OF_SETS);

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [NUM_PORTS-1:0]    grant_q;
    logic                    wr_q;
    logic [MW-1:0]           mem_idx_q;
    logic [BLOCK_SIZE-1:0]   wdata_q;
    logic [BLOCK_SIZE-1:0]   rdata_q;
    logic [NUM_PORTS-1:0]    rd_valid_q;
    logic [NUM_PORTS-1:0]    done_q;
    logic [NUM_PORTS-1:0]    inv_q;

    logic [BLOCK_SIZE-1:0]   mem_q [NO_OF_SETS];

    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS-1:0]    grant;
    logic [GW-1:0]           grant_idx;
    logic [AW-1:0]           addr_w;
    logic                    addr_ok;
    logic                    mem_we;

    assign req     = mem_rd | mem_wr;
    assign addr_w  = {tag_in[grant_idx*TAG_BITS +: TAG_BITS],
                      index_in[grant_idx*INDEX_BITS +: INDEX_BITS]};
    assign addr_ok = {1'b0, addr_w} < SETS;

    mem_port_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
`ifdef MEM_RR_ARB_EN
        .clk_i       (CLK),
        .rst_ni      (RST),
        .advance_i   ((state_q == IDLE) && (|req)),
`endif
        .req_i       (req),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Reset forces IDLE asynchronously, so a pending write can never reach commit.
    assign mem_we = (state_q == BUSY) && (cnt_q == '0) && wr_q;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            wr_q       <= 1'b0;
            mem_idx_q  <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= '0;
            done_q     <= '0;
            inv_q      <= '0;
        end else begin
            rd_valid_q <= '0;
            done_q     <= '0;
            inv_q      <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q   <= grant;
                        wr_q      <= mem_wr[grant_idx];
                        mem_idx_q <= addr_w[MW-1:0];
                        wdata_q   <= wdata_in[grant_idx*BLOCK_SIZE +: BLOCK_SIZE];
                        if (addr_ok) begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(LATENCY - 1);
                        end else begin
                            state_q <= RESP;
                            done_q  <= grant;
                            inv_q   <= grant;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        done_q  <= grant_q;
                        if (!wr_q) begin
                            rd_valid_q <= grant_q;
                            rdata_q    <= mem_q[mem_idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata_out    = rdata_q;
    assign rd_valid     = rd_valid_q;
    assign done         = done_q;
    assign invalid_addr = inv_q;
    assign busy         = (state_q != IDLE);

endmodule
